// File: rtl/ring_scan_display.sv
// Time-multiplexed 4-digit common-anode 7-segment driver clocked by a one-hot ring phase.
// Optional macro RING_SEQ_CHECK_EN adds a phase-order check on top of the one-hot check.
module ring_scan_display #(
  parameter int unsigned FRAME_W = 8,
  parameter int unsigned ERR_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         q,
  input  logic [15:0]        data_in,
  input  logic               data_valid,
  output logic               data_ready,
  output logic [3:0]         an,
  output logic [6:0]         seg,
  output logic               ring_err,
  output logic [ERR_W-1:0]   err_cnt,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam logic [3:0]       PH_FIRST = 4'b0001;
  localparam logic [3:0]       PH_LAST  = 4'b1000;
  localparam logic [3:0]       AN_OFF   = 4'b1111;
  localparam logic [6:0]       SEG_OFF  = 7'h7F;
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  logic [3:0]         r_prev;
  logic [15:0]        r_disp;
  logic [15:0]        r_pend;
  logic               r_ready;
  logic [3:0]         r_an;
  logic [6:0]         r_seg;
  logic               r_ring_err;
  logic [ERR_W-1:0]   r_err_cnt;
  logic [FRAME_W-1:0] r_frame_cnt;

  logic        w_onehot;
  logic        w_order_bad;
  logic        w_illegal;
  logic        w_boundary;
  logic        w_load;
  logic [15:0] w_disp_next;
  logic [3:0]  w_digit;
  logic [6:0]  w_seg;

  assign w_onehot = (q != 4'b0000) && ((q & (q - 4'd1)) == 4'b0000);

`ifdef RING_SEQ_CHECK_EN
  logic       w_prev_onehot;
  logic [3:0] w_prev_rotl;
  assign w_prev_onehot = (r_prev != 4'b0000) && ((r_prev & (r_prev - 4'd1)) == 4'b0000);
  assign w_prev_rotl   = {r_prev[2:0], r_prev[3]};
  // Order is only judged against a known-good previous phase.
  assign w_order_bad   = w_onehot && w_prev_onehot && (q != r_prev) && (q != w_prev_rotl);
`else
  assign w_order_bad   = 1'b0;
`endif

  assign w_illegal  = !w_onehot || w_order_bad;
  assign w_boundary = (q == PH_FIRST) && (r_prev == PH_LAST);
  assign w_load     = w_boundary && !r_ready;

  // Digit is chosen from the post-load value so new data appears with phase 0001.
  assign w_disp_next = w_load ? r_pend : r_disp;

  always_comb begin
    w_digit = 4'h0;
    case (q)
      4'b0001: w_digit = w_disp_next[3:0];
      4'b0010: w_digit = w_disp_next[7:4];
      4'b0100: w_digit = w_disp_next[11:8];
      4'b1000: w_digit = w_disp_next[15:12];
      default: w_digit = 4'h0;
    endcase
  end

  always_comb begin
    w_seg = SEG_OFF;
    case (w_digit)
      4'h0: w_seg = 7'h40;
      4'h1: w_seg = 7'h79;
      4'h2: w_seg = 7'h24;
      4'h3: w_seg = 7'h30;
      4'h4: w_seg = 7'h19;
      4'h5: w_seg = 7'h12;
      4'h6: w_seg = 7'h02;
      4'h7: w_seg = 7'h78;
      4'h8: w_seg = 7'h00;
      4'h9: w_seg = 7'h10;
      4'hA: w_seg = 7'h08;
      4'hB: w_seg = 7'h03;
      4'hC: w_seg = 7'h46;
      4'hD: w_seg = 7'h21;
      4'hE: w_seg = 7'h06;
      4'hF: w_seg = 7'h0E;
      default: w_seg = SEG_OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev      <= 4'b0000;
      r_disp      <= 16'h0000;
      r_pend      <= 16'h0000;
      r_ready     <= 1'b1;
      r_an        <= AN_OFF;
      r_seg       <= SEG_OFF;
      r_ring_err  <= 1'b0;
      r_err_cnt   <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_prev <= q;
      r_disp <= w_disp_next;

      // Load and capture are exclusive: load needs a full buffer, capture an empty one.
      if (w_load) begin
        r_ready <= 1'b1;
      end else if (data_valid && r_ready) begin
        r_pend  <= data_in;
        r_ready <= 1'b0;
      end

      if (w_boundary) begin
        r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
      end

      if (w_illegal) begin
        r_an       <= AN_OFF;
        r_seg      <= SEG_OFF;
        r_ring_err <= 1'b1;
        if (r_err_cnt != ERR_MAX) begin
          r_err_cnt <= r_err_cnt + ERR_W'(1);
        end
      end else begin
        r_an  <= ~q;
        r_seg <= w_seg;
      end
    end
  end

  assign data_ready = r_ready;
  assign an         = r_an;
  assign seg        = r_seg;
  assign ring_err   = r_ring_err;
  assign err_cnt    = r_err_cnt;
  assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_ring_scan_display.sv
// Directed bench for ring_scan_display: vector table plus hand sequences for handshake, reset and wrap cases.
module tb_ring_scan_display;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  q;
  logic [15:0] data_in;
  logic        data_valid;
  logic        data_ready;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        ring_err;
  logic [7:0]  err_cnt;
  logic [7:0]  frame_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ring_scan_display #(.FRAME_W(8), .ERR_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .q          (q),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .an         (an),
    .seg        (seg),
    .ring_err   (ring_err),
    .err_cnt    (err_cnt),
    .frame_cnt  (frame_cnt)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  q;
    logic        dv;
    logic [15:0] din;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        rdy;
    logic [7:0]  frame;
    logic [7:0]  err;
    logic        rerr;
  } vec_t;

  vec_t tbl [$];

`ifdef RING_SEQ_CHECK_EN
  localparam logic [7:0] ERR_AFTER_OOO = 8'd4;
`else
  localparam logic [7:0] ERR_AFTER_OOO = 8'd3;
`endif

  function automatic vec_t mk(logic rst, logic [3:0] qq, logic dv, logic [15:0] din,
                              logic [3:0] ean, logic [6:0] eseg, logic rdy,
                              logic [7:0] frame, logic [7:0] err, logic rerr);
    vec_t v;
    v.rst = rst; v.q = qq; v.dv = dv; v.din = din;
    v.an = ean; v.seg = eseg; v.rdy = rdy; v.frame = frame; v.err = err; v.rerr = rerr;
    return v;
  endfunction

  task automatic cmp(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the edge.
  task automatic apply(input vec_t v, input int idx);
    reset      = v.rst;
    q          = v.q;
    data_valid = v.dv;
    data_in    = v.din;
    @(posedge clk);
    #1;
    cmp("an",        idx, 16'(an),         16'(v.an));
    cmp("seg",       idx, 16'(seg),        16'(v.seg));
    cmp("ready",     idx, 16'(data_ready), 16'(v.rdy));
    cmp("frame_cnt", idx, 16'(frame_cnt),  16'(v.frame));
    cmp("err_cnt",   idx, 16'(err_cnt),    16'(v.err));
    cmp("ring_err",  idx, 16'(ring_err),   16'(v.rerr));
  endtask

  task automatic drive(input logic rst, input logic [3:0] qq, input logic dv, input logic [15:0] din);
    reset = rst; q = qq; data_valid = dv; data_in = din;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; q = 4'b0000; data_valid = 1'b0; data_in = 16'h0000;

    // Reset and an empty first frame.
    tbl.push_back(mk(1, 4'b0000, 0, 16'h0000, 4'b1111, 7'h7F, 1, 8'd0, 8'd0, 0));
    tbl.push_back(mk(0, 4'b0001, 0, 16'h0000, 4'b1110, 7'h40, 1, 8'd0, 8'd0, 0));
    tbl.push_back(mk(0, 4'b0010, 0, 16'h0000, 4'b1101, 7'h40, 1, 8'd0, 8'd0, 0));
    tbl.push_back(mk(0, 4'b0100, 0, 16'h0000, 4'b1011, 7'h40, 1, 8'd0, 8'd0, 0));
    tbl.push_back(mk(0, 4'b1000, 0, 16'h0000, 4'b0111, 7'h40, 1, 8'd0, 8'd0, 0));
    tbl.push_back(mk(0, 4'b0001, 0, 16'h0000, 4'b1110, 7'h40, 1, 8'd1, 8'd0, 0));
    tbl.push_back(mk(0, 4'b0010, 0, 16'h0000, 4'b1101, 7'h40, 1, 8'd1, 8'd0, 0));
    // Push 1A3F mid-frame; current frame still shows zeros.
    tbl.push_back(mk(0, 4'b0100, 1, 16'h1A3F, 4'b1011, 7'h40, 0, 8'd1, 8'd0, 0));
    tbl.push_back(mk(0, 4'b1000, 0, 16'h0000, 4'b0111, 7'h40, 0, 8'd1, 8'd0, 0));
    tbl.push_back(mk(0, 4'b0001, 0, 16'h0000, 4'b1110, 7'h0E, 1, 8'd2, 8'd0, 0));
    tbl.push_back(mk(0, 4'b0010, 0, 16'h0000, 4'b1101, 7'h30, 1, 8'd2, 8'd0, 0));
    tbl.push_back(mk(0, 4'b0100, 0, 16'h0000, 4'b1011, 7'h08, 1, 8'd2, 8'd0, 0));
    tbl.push_back(mk(0, 4'b1000, 0, 16'h0000, 4'b0111, 7'h79, 1, 8'd2, 8'd0, 0));
    // Illegal two-hot phase for three cycles.
    tbl.push_back(mk(0, 4'b0110, 0, 16'h0000, 4'b1111, 7'h7F, 1, 8'd2, 8'd1, 1));
    tbl.push_back(mk(0, 4'b0110, 0, 16'h0000, 4'b1111, 7'h7F, 1, 8'd2, 8'd2, 1));
    tbl.push_back(mk(0, 4'b0110, 0, 16'h0000, 4'b1111, 7'h7F, 1, 8'd2, 8'd3, 1));
    // 0110 -> 0001 is not a frame boundary.
    tbl.push_back(mk(0, 4'b0001, 0, 16'h0000, 4'b1110, 7'h0E, 1, 8'd2, 8'd3, 1));
    tbl.push_back(mk(0, 4'b0010, 0, 16'h0000, 4'b1101, 7'h30, 1, 8'd2, 8'd3, 1));
    tbl.push_back(mk(0, 4'b0100, 0, 16'h0000, 4'b1011, 7'h08, 1, 8'd2, 8'd3, 1));
    tbl.push_back(mk(0, 4'b1000, 0, 16'h0000, 4'b0111, 7'h79, 1, 8'd2, 8'd3, 1));
    tbl.push_back(mk(0, 4'b0001, 0, 16'h0000, 4'b1110, 7'h0E, 1, 8'd3, 8'd3, 1));
    // Out-of-order one-hot 0001 -> 0100.
`ifdef RING_SEQ_CHECK_EN
    tbl.push_back(mk(0, 4'b0100, 0, 16'h0000, 4'b1111, 7'h7F, 1, 8'd3, 8'd4, 1));
`else
    tbl.push_back(mk(0, 4'b0100, 0, 16'h0000, 4'b1011, 7'h08, 1, 8'd3, 8'd3, 1));
`endif

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Back-to-back pushes with valid held: 1111 waits for nothing, 2222 waits for the boundary.
    apply(mk(0, 4'b1000, 1, 16'h1111, 4'b0111, 7'h79, 0, 8'd3, ERR_AFTER_OOO, 1), 100);
    apply(mk(0, 4'b0001, 1, 16'h1111, 4'b1110, 7'h79, 1, 8'd4, ERR_AFTER_OOO, 1), 101);
    apply(mk(0, 4'b0010, 1, 16'h2222, 4'b1101, 7'h79, 0, 8'd4, ERR_AFTER_OOO, 1), 102);
    apply(mk(0, 4'b0100, 1, 16'h2222, 4'b1011, 7'h79, 0, 8'd4, ERR_AFTER_OOO, 1), 103);
    apply(mk(0, 4'b1000, 1, 16'h2222, 4'b0111, 7'h79, 0, 8'd4, ERR_AFTER_OOO, 1), 104);
    apply(mk(0, 4'b0001, 1, 16'h2222, 4'b1110, 7'h24, 1, 8'd5, ERR_AFTER_OOO, 1), 105);
    apply(mk(0, 4'b0010, 0, 16'h0000, 4'b1101, 7'h24, 1, 8'd5, ERR_AFTER_OOO, 1), 106);
    apply(mk(0, 4'b0100, 1, 16'hBEEF, 4'b1011, 7'h24, 0, 8'd5, ERR_AFTER_OOO, 1), 107);

    // Reset mid-frame with pending data: everything cleared, pending aborted.
    apply(mk(1, 4'b1000, 0, 16'h0000, 4'b1111, 7'h7F, 1, 8'd0, 8'd0, 0), 200);
    apply(mk(0, 4'b0001, 0, 16'h0000, 4'b1110, 7'h40, 1, 8'd0, 8'd0, 0), 201);
    apply(mk(0, 4'b0010, 0, 16'h0000, 4'b1101, 7'h40, 1, 8'd0, 8'd0, 0), 202);
    apply(mk(0, 4'b0100, 0, 16'h0000, 4'b1011, 7'h40, 1, 8'd0, 8'd0, 0), 203);
    apply(mk(0, 4'b1000, 0, 16'h0000, 4'b0111, 7'h40, 1, 8'd0, 8'd0, 0), 204);
    apply(mk(0, 4'b0001, 0, 16'h0000, 4'b1110, 7'h40, 1, 8'd1, 8'd0, 0), 205);

    // Frame counter wrap: 255 more frames bring it from 1 back to 0.
    for (int f = 0; f < 255; f++) begin
      drive(0, 4'b0010, 0, 16'h0000);
      drive(0, 4'b0100, 0, 16'h0000);
      drive(0, 4'b1000, 0, 16'h0000);
      drive(0, 4'b0001, 0, 16'h0000);
    end
    cmp("frame_wrap", 300, 16'(frame_cnt), 16'h0000);
    cmp("wrap_seg",   300, 16'(seg),       16'h0040);

    // Error counter saturation with q stuck at zero.
    for (int e = 0; e < 260; e++) drive(0, 4'b0000, 0, 16'h0000);
    cmp("err_sat",    301, 16'(err_cnt),  16'h00FF);
    cmp("ring_err",   301, 16'(ring_err), 16'h0001);
    cmp("blank_an",   301, 16'(an),       16'h000F);
    cmp("frame_hold", 301, 16'(frame_cnt), 16'h0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ring_scan_display.md
Name: ring_scan_display

Overview:
- Downstream consumer of the 4-bit one-hot ring counter output.
- Uses the ring phase to time-multiplex a 4-digit common-anode 7-segment display from a 16-bit hex value.
- Accepts new display data via a valid/ready handshake; updates are applied only at frame boundaries, so a frame never shows a mix of old and new digits.
- Checks the ring sequence for illegal states and counts completed scan frames.

Parameters:
- FRAME_W, 8, width of the frame counter; wraps modulo 2^FRAME_W.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- q  input  4  one-hot phase from the ring counter; q[i] selects digit i.
- data_in  input  16  hex value; digit i = data_in[4i+3:4i].
- data_valid  input  1  data_in is offered.
- data_ready  output  1  block can accept data_in.
- an  output  4  anode enables, active-low.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- ring_err  output  1  sticky illegal-ring flag.
- err_cnt  output  ERR_W  count of cycles with an illegal ring state, saturating.
- frame_cnt  output  FRAME_W  completed frames.

Behaviour:
- Reset values (synchronous): an=4'b1111, seg=7'h7F, data_ready=1, ring_err=0, err_cnt=0, frame_cnt=0.
  - Display register = 16'h0000; pending buffer empty; previous-phase register = 4'b0000.
- Legal ring sequence: 0001->0010->0100->1000->0001. Holding the same phase for several cycles is legal.
- Legal phase: q has exactly one bit set.
- Illegal phase: q=0000 or two or more bits set.
- Handshake:
  - data_ready = ~pending_full.
  - Transfer occurs when data_valid & data_ready at a rising edge: data_in is captured into the 1-entry pending buffer and pending_full goes to 1.
  - data_valid with data_ready=0 is ignored; the source must hold its data until ready.
- Frame boundary: sampled q==0001 while previous q==1000.
  - At a frame boundary, a full pending buffer moves into the display register and pending_full clears.
  - data_ready therefore rises the cycle after the boundary.
  - New digits are first displayed in the same output update as phase 0001, because the digit is selected from the post-load value.
  - frame_cnt increments at every frame boundary and wraps from 2^FRAME_W-1 to 0.
- Output pipeline: one cycle of latency. At edge t, sampled q determines the an/seg values visible after edge t.
  - Legal q: an = ~q; seg = hex-to-7seg of the selected digit.
  - Encodings: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.
  - Illegal q: an=4'b1111, seg=7'h7F (blank); ring_err set and held until reset; err_cnt += 1, saturating at all-ones.
- The previous-phase register updates every cycle, including on illegal q. After an illegal state, no frame boundary is recognised until a genuine 1000->0001 sequence occurs.
- Reset during operation aborts any pending data, blanks the display and clears all counters in the same edge.
- Reset has priority over a simultaneous handshake or frame boundary.

Optional Feature:
- Macro: RING_SEQ_CHECK_EN.
- Defined: an order check is added. A legal one-hot q that is neither equal to the previous q nor equal to rotate-left(previous q) counts as illegal (blank output, ring_err, err_cnt).
  - The check is skipped when the previous q was 0000 or illegal, e.g. the first cycle after reset.
- Not defined: only the one-hot check applies, and out-of-order one-hot phases are displayed normally.

Test Plan:
- Reset, then q cycles 0001,0010,0100,1000 with no data -> an = 1110,1101,1011,0111 one cycle later; seg=7'h40 every cycle; frame_cnt=0 until the first 1000->0001, then 1.
- Push data_in=16'h1A3F with valid while q=0100 -> data_ready drops the next cycle; the current frame still shows 0.
  - At the next 0001, seg=7'h0E (digit0 F), then 7'h30, 7'h08, 7'h79 for digits 1-3; data_ready=1 after the boundary.
- Two back-to-back pushes 16'h1111 then 16'h2222 with valid held -> the second waits with ready=0 until the boundary.
  - Frame N shows 1111, frame N+1 shows 2222; no digit is lost or torn.
- Drive q=0110 for 3 cycles, then resume the legal sequence -> an=1111, seg=7'h7F for those cycles; ring_err=1 stays set; err_cnt=3.
  - frame_cnt does not increment until a real 1000->0001.
- With RING_SEQ_CHECK_EN: q 0001->0100 -> blank, err_cnt+1. Without the macro -> an=1011 and digit2 is displayed.
- Assert reset mid-frame with pending data -> the next cycle has an=1111, seg=7'h7F, ready=1, counters 0, and the display register is 0000.
